// File: rtl/exec_pkg.sv
// Shared types for the integer execute writeback path: in-flight tag layout and trap causes.
package exec_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int ALEN_DEF  = 32;
  localparam int DEPTH_DEF = 2;

  typedef enum logic [3:0] {
    CAUSE_MISALIGN_FETCH = 4'd0,
    CAUSE_FETCH_FAULT    = 4'd1,
    CAUSE_ILLEGAL        = 4'd2,
    CAUSE_BREAKPOINT     = 4'd3,
    CAUSE_MISALIGN_LOAD  = 4'd4,
    CAUSE_LOAD_FAULT     = 4'd5
  } trap_cause_e;

  // addr width is fixed by the package; the top-level ALEN must match it
  typedef struct packed {
    logic [4:0]          rd;
    logic [ALEN_DEF-1:0] addr;
    logic                killed;
  } inflight_t;
endpackage

// File: rtl/exec_int_writeback_inflight_fifo.sv
// Circular tag FIFO with wrap-bit pointers and a kill-all port that poisons every stored entry.
module inflight_fifo
  import exec_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  inflight_t push_data,
  input  logic      pop,
  input  logic      kill_all,
  output inflight_t head,
  output logic      full,
  output logic      empty
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wrptr, rdptr;
  inflight_t   mem [DEPTH];

  assign empty = (wrptr == rdptr);
  assign full  = (wrptr[PW] != rdptr[PW]) && (wrptr[PW-1:0] == rdptr[PW-1:0]);
  assign head  = mem[rdptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrptr <= '0;
      rdptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (kill_all)
        for (int i = 0; i < DEPTH; i++) mem[i].killed <= 1'b1;
      // an entry pushed alongside the kill is younger than the faulting op, so it dies too
      if (push) begin
        mem[wrptr[PW-1:0]]        <= push_data;
        mem[wrptr[PW-1:0]].killed <= push_data.killed | kill_all;
        wrptr                     <= wrptr + 1'b1;
      end
      if (pop) rdptr <= rdptr + 1'b1;
    end
  end
endmodule

// File: rtl/exec_int_writeback.sv
// Result consumer for exec_int: matches result strobes to in-flight ops, writes the regfile,
// raises traps, and keeps a per-register busy scoreboard for decode hazard checks.
module exec_int_writeback
  import exec_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int ALEN  = ALEN_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [4:0]      issue_rd,
  input  logic            issue_is_muldiv,
  input  logic [ALEN-1:0] issue_addr,
  input  logic            exec_int_output_valid,
  input  logic            exec_int_exception,
  input  logic [3:0]      exec_int_trap_cause,
  input  logic [XLEN-1:0] exec_int_result,
  input  logic [4:0]      query_rs1,
  input  logic [4:0]      query_rs2,
  output logic            query_hazard,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            trap_valid,
  output logic [3:0]      trap_cause,
  output logic [ALEN-1:0] trap_addr,
  input  logic            trap_ack,
  output logic            protocol_error
);
  localparam int CW = $clog2(DEPTH + 1);

  inflight_t           push_data, head;
  logic                full, empty, fire, pop, kill_all, muldiv_shadow;
  logic                inc, dec;
  logic [31:0][CW-1:0] cnt;
  logic [31:0]         busy;

  assign issue_ready = !full && !trap_valid && !muldiv_shadow;
  assign fire        = issue_valid && issue_ready;
  assign pop         = exec_int_output_valid && !empty;
  assign kill_all    = pop && !head.killed && exec_int_exception;
  assign inc         = fire && (issue_rd != 5'd0);
  assign dec         = pop && (head.rd != 5'd0);

  always_comb begin
    push_data        = '0;
    push_data.rd     = issue_rd;
    push_data.addr   = issue_addr;
    push_data.killed = 1'b0;
  end

  inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fire),
    .push_data (push_data),
    .pop       (pop),
    .kill_all  (kill_all),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    busy = '0;
    for (int r = 1; r < 32; r++) busy[r] = (cnt[r] != '0);
  end

  // no same-cycle pop bypass: decode sees the busy bit drop one cycle after the result
  assign query_hazard = busy[query_rs1] || busy[query_rs2];

  // per-register in-flight count, so a younger op to the same rd keeps the bit set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        case ({inc && (issue_rd == 5'(r)), dec && (head.rd == 5'(r))})
          2'b10:   cnt[r] <= cnt[r] + 1'b1;
          2'b01:   cnt[r] <= cnt[r] - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      muldiv_shadow  <= 1'b0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      trap_valid     <= 1'b0;
      trap_cause     <= '0;
      trap_addr      <= '0;
      protocol_error <= 1'b0;
    end else begin
      muldiv_shadow <= fire && issue_is_muldiv;
      wb_valid      <= 1'b0;
      if (exec_int_output_valid && empty) protocol_error <= 1'b1;
      if (trap_valid && trap_ack) trap_valid <= 1'b0;
      if (pop && !head.killed) begin
        if (exec_int_exception) begin
          if (!trap_valid) begin
            trap_valid <= 1'b1;
            trap_cause <= exec_int_trap_cause;
            trap_addr  <= head.addr;
          end
        end else if (head.rd != 5'd0) begin
          wb_valid <= 1'b1;
          wb_rd    <= head.rd;
          wb_data  <= exec_int_result;
        end
      end
    end
  end
endmodule
